// File: rtl/tone_demodulator.sv
// rtl/tone_demodulator.sv - 8-tone on/off keying period classifier with lock detection and one-hot tone output
// Optional feature: define DEMOD_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchronizer.
module tone_demodulator #(
  parameter int CNT_W   = 18,
  parameter int TONE0_P = 75592,
  parameter int TONE1_P = 84848,
  parameter int TONE2_P = 95240,
  parameter int TONE3_P = 100902,
  parameter int TONE4_P = 113260,
  parameter int TONE5_P = 127130,
  parameter int TONE6_P = 142698,
  parameter int TONE7_P = 151182,
  parameter int TOL     = 1000,
  parameter int MATCH_N = 3,
  parameter int TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       carrier_det
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [CNT_W-1:0] TONE_P [8] = '{
    CNT_W'(TONE0_P), CNT_W'(TONE1_P), CNT_W'(TONE2_P), CNT_W'(TONE3_P),
    CNT_W'(TONE4_P), CNT_W'(TONE5_P), CNT_W'(TONE6_P), CNT_W'(TONE7_P)
  };
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic signed [CNT_W:0] TOL_C = (CNT_W+1)'(TOL);
  localparam logic [3:0] MATCH_C = 4'(MATCH_N);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic edge_src;
  logic edge_det;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [2:0]       cand_q, cand_d;
  logic [3:0]       run_q, run_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             carrier_q, carrier_d;

  logic [CNT_W-1:0]   period;
  logic signed [CNT_W:0] diff;
  logic signed [CNT_W:0] adiff;
  logic               match;
  logic [2:0]         match_k;
  logic [3:0]         run_next;
  logic               timeout;

`ifdef DEMOD_GLITCH_FILTER_EN
  logic f1_q, f1_d;
  logic f2_q, f2_d;
  logic filt_q, filt_d;

  // Majority of three consecutive synchronized samples; a 1-clk pulse never wins the vote
  always_comb begin
    f1_d   = sync2_q;
    f2_d   = f1_q;
    filt_d = (sync2_q & f1_q) | (sync2_q & f2_q) | (f1_q & f2_q);
  end

  // Filter history and registered vote
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f1_q   <= 1'b0;
      f2_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      f1_q   <= f1_d;
      f2_q   <= f2_d;
      filt_q <= filt_d;
    end
  end

  assign edge_src = filt_q;
`else
  assign edge_src = sync2_q;
`endif

  // Two-flop synchronizer plus previous-sample register for rising edge detection
  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    prev_d  = edge_src;
  end

  assign edge_det = edge_src & ~prev_q;

  // Period counter: restarts on each edge, saturates so it never wraps
  always_comb begin
    if (edge_det) begin
      cnt_d = '0;
    end else if (cnt_q == TIMEOUT_C) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign period  = cnt_q + CNT_W'(1);
  assign timeout = (state_q != IDLE) && (cnt_q == TIMEOUT_C);

  // Classify the measured period; scanning downward lets the lowest matching tone win
  always_comb begin
    match   = 1'b0;
    match_k = 3'd0;
    diff    = '0;
    adiff   = '0;
    for (int k = 7; k >= 0; k--) begin
      diff  = $signed({1'b0, period}) - $signed({1'b0, TONE_P[k]});
      adiff = diff[CNT_W] ? -diff : diff;
      if (adiff <= TOL_C) begin
        match   = 1'b1;
        match_k = 3'(k);
      end
    end
  end

  // Lock state machine and registered outputs
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    run_d     = run_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    carrier_d = carrier_q;
    run_next  = 4'd0;
    if (timeout) begin
      // A coincident edge becomes the new reference edge
      state_d   = edge_det ? ARMED : IDLE;
      run_d     = 4'd0;
      data_d    = 8'h00;
      carrier_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (edge_det) state_d = ARMED;
        end
        ARMED: begin
          if (edge_det) begin
            if (!match) begin
              run_d = 4'd0;
            end else begin
              if (match_k == cand_q) begin
                run_next = run_q + 4'd1;
              end else begin
                run_next = 4'd1;
                cand_d   = match_k;
              end
              run_d = run_next;
              if (run_next >= MATCH_C) begin
                state_d   = LOCKED;
                data_d    = 8'h01 << match_k;
                carrier_d = 1'b1;
                valid_d   = 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          if (edge_det) begin
            if (!match) begin
              state_d   = ARMED;
              run_d     = 4'd0;
              data_d    = 8'h00;
              carrier_d = 1'b0;
            end else if (match_k != cand_q) begin
              state_d   = ARMED;
              cand_d    = match_k;
              run_d     = 4'd1;
              data_d    = 8'h00;
              carrier_d = 1'b0;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          run_d     = 4'd0;
          data_d    = 8'h00;
          carrier_d = 1'b0;
        end
      endcase
    end
  end

  // All state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      state_q   <= IDLE;
      cand_q    <= 3'd0;
      run_q     <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      carrier_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      run_q     <= run_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      carrier_q <= carrier_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign carrier_det = carrier_q;

endmodule

// File: tb/tb_tone_demodulator.sv
// tb/tb_tone_demodulator.sv - directed vector bench for tone_demodulator with scaled tone periods
module tb_tone_demodulator;

  localparam int T0 = 40;
  localparam int T1 = 50;
  localparam int T2 = 60;
  localparam int T3 = 70;
  localparam int T4 = 80;
  localparam int T5 = 90;
  localparam int T6 = 100;
  localparam int T7 = 120;
  localparam int TOL_P = 5;
  localparam int TMO = 200;
  localparam int HI = 10;

  logic       clk;
  logic       rst;
  logic       sig_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       carrier_det;

  int total;
  int bad;
  int strobes;
  int rst_viol;

  tone_demodulator #(
    .CNT_W(8), .TONE0_P(T0), .TONE1_P(T1), .TONE2_P(T2), .TONE3_P(T3),
    .TONE4_P(T4), .TONE5_P(T5), .TONE6_P(T6), .TONE7_P(T7),
    .TOL(TOL_P), .MATCH_N(3), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sig_in(sig_in),
    .data_out(data_out),
    .data_valid(data_valid),
    .carrier_det(carrier_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) strobes++;
    if (!rst && (data_out != 8'h00 || carrier_det || data_valid)) rst_viol++;
  end

  typedef struct {
    int         period;
    int         n_edges;
    logic [7:0] exp_data;
    int         exp_strobes;
    logic       exp_carrier;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // each call produces n rising edges, each exactly p cycles after the previous rise
  task automatic wave(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b0;
      cycles(p - HI);
      sig_in = 1'b1;
      cycles(HI);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sig_in = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(2);
    strobes = 0;
  endtask

  initial begin
    int s0;
    total = 0;
    bad = 0;
    strobes = 0;
    rst_viol = 0;
    rst = 1'b0;
    sig_in = 1'b0;

    vecs[0]  = '{T0,  4, 8'h01, 1, 1'b1};
    vecs[1]  = '{T7,  4, 8'h80, 1, 1'b1};
    vecs[2]  = '{111, 6, 8'h00, 0, 1'b0};
    vecs[3]  = '{T3,  3, 8'h00, 0, 1'b0};
    vecs[4]  = '{45,  4, 8'h01, 1, 1'b1};
    vecs[5]  = '{35,  4, 8'h01, 1, 1'b1};
    vecs[6]  = '{34,  5, 8'h00, 0, 1'b0};
    vecs[7]  = '{125, 4, 8'h80, 1, 1'b1};
    vecs[8]  = '{126, 4, 8'h00, 0, 1'b0};
    vecs[9]  = '{55,  4, 8'h02, 1, 1'b1};
    vecs[10] = '{84,  6, 8'h10, 1, 1'b1};

    // reset held low while the line toggles
    cycles(2);
    check("reset_data", int'(data_out), 0);
    check("reset_valid", int'(data_valid), 0);
    check("reset_carrier", int'(carrier_det), 0);
    wave(T0, 5);
    check("in_reset_strobes", strobes, 0);
    check("in_reset_outputs", rst_viol, 0);

    // table-driven vectors, fresh reset each
    for (int v = 0; v < 11; v++) begin
      do_reset();
      wave(vecs[v].period, vecs[v].n_edges);
      check($sformatf("vec%0d_data", v), int'(data_out), int'(vecs[v].exp_data));
      check($sformatf("vec%0d_strobes", v), strobes, vecs[v].exp_strobes);
      check($sformatf("vec%0d_carrier", v), int'(carrier_det), int'(vecs[v].exp_carrier));
    end

    // tone change while locked: tone2 -> tone5
    do_reset();
    wave(T2, 4);
    check("sw_lock2_data", int'(data_out), 8'h04);
    check("sw_lock2_strobes", strobes, 1);
    wave(T5, 1);
    check("sw_first5_data", int'(data_out), 0);
    check("sw_first5_carrier", int'(carrier_det), 0);
    wave(T5, 1);
    check("sw_second5_data", int'(data_out), 0);
    wave(T5, 1);
    check("sw_third5_data", int'(data_out), 8'h20);
    check("sw_third5_strobes", strobes, 2);

    // carrier loss after the timeout, then relock
    do_reset();
    wave(T0, 4);
    check("to_lock_carrier", int'(carrier_det), 1);
    sig_in = 1'b0;
    cycles(195 - HI);
    check("to_before_carrier", int'(carrier_det), 1);
    cycles(15);
    check("to_after_carrier", int'(carrier_det), 0);
    check("to_after_data", int'(data_out), 0);
    wave(T0, 3);
    check("to_relock_partial", int'(data_out), 0);
    wave(T0, 1);
    check("to_relock_data", int'(data_out), 8'h01);
    check("to_relock_strobes", strobes, 2);

    // async reset while locked
    do_reset();
    wave(T1, 4);
    check("mr_locked_data", int'(data_out), 8'h02);
    #3;
    rst = 1'b0;
    #1;
    check("mr_data_immediate", int'(data_out), 0);
    check("mr_carrier_immediate", int'(carrier_det), 0);
    cycles(3);
    s0 = strobes;
    rst = 1'b1;
    cycles(20);
    check("mr_no_strobe", strobes, s0);
    check("mr_data_after", int'(data_out), 0);

    // single-clock spikes in the low phase of a locked tone0
    do_reset();
    wave(T0, 4);
    s0 = strobes;
    for (int i = 0; i < 2; i++) begin
      sig_in = 1'b0;
      cycles(15);
      sig_in = 1'b1;
      cycles(1);
      sig_in = 1'b0;
      cycles(T0 - HI - 16);
      sig_in = 1'b1;
      cycles(HI);
    end
`ifdef DEMOD_GLITCH_FILTER_EN
    check("glitch_data", int'(data_out), 8'h01);
    check("glitch_carrier", int'(carrier_det), 1);
    check("glitch_strobes", strobes, s0);
`else
    check("glitch_data", int'(data_out), 0);
    check("glitch_carrier", int'(carrier_det), 0);
    check("glitch_strobes", strobes, s0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
